cmp_sweep_checker: RTL and testbench

Self-checking stimulus and response engine for the team's combinational magnitude comparators. It is the driving/checking end of the comparator interface. It sweeps every (A,B) operand pair of a WIDTH-bit comparator and samples the three relation outputs. Each sample is checked against an internal golden relation, and the block reports pass/fail, error count and the first failing pair. Intended for on-chip BIST wrappers and as a synthesizable bench component around comparator DUTs.

---
 rtl/cmp_sweep_checker.sv | 159 +++++++++++++++
 tb/tb_cmp_sweep_checker.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : cmp_sweep_checker
// Description : Exhaustive stimulus/response engine for a WIDTH-bit
//               combinational magnitude comparator. It drives every (A,B)
//               pair in order (B is the fast-moving field) and holds each pair
//               for SETTLE cycles. It then samples the comparator's gt/lt/eq
//               outputs for one cycle and checks them against the unsigned
//               relation. It reports pass, the number of failing vectors and
//               the first failing pair.
// Ports       : clk, rst (async, active-high)
//               start                  - begin a sweep (IDLE/DONE only)
//               a_out, b_out           - operands to the comparator
//               gt_in, lt_in, eq_in    - comparator relation outputs
//               busy, done, pass       - status
//               err_count              - failing vectors in last sweep
//               first_fail_a/b         - first failing pair (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module cmp_sweep_checker #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic             gt_in,
  input  logic             lt_in,
  input  logic             eq_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2*WIDTH:0] err_count,
  output logic [WIDTH-1:0] first_fail_a,
  output logic [WIDTH-1:0] first_fail_b
);

  localparam int            c_CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_CW-1:0] c_SETTLE_LAST = c_CW'(SETTLE - 1);
  localparam logic [2*WIDTH-1:0] c_VEC_ONE  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH:0]   c_ERR_ONE  = {{(2*WIDTH){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [c_CW-1:0]   settle_q, settle_d;
  logic [2*WIDTH:0]  err_q, err_d;
  logic [WIDTH-1:0]  ffa_q, ffa_d;
  logic [WIDTH-1:0]  ffb_q, ffb_d;
  logic              pass_q, pass_d;

  logic              w_fail;
  logic              w_last;
  logic [2*WIDTH-1:0] w_vec_next;

  // Any disagreement on any of the three lines is a failure, which also
  // catches all-zero and multiple-high responses.
  assign w_fail     = (gt_in != (a_q >  b_q)) |
                      (lt_in != (a_q <  b_q)) |
                      (eq_in != (a_q == b_q));
  assign w_last     = &{a_q, b_q};
  assign w_vec_next = {a_q, b_q} + c_VEC_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ffa_q    <= '0;
      ffb_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ffa_q    <= ffa_d;
      ffb_q    <= ffb_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    settle_d = settle_q;
    err_d    = err_q;
    ffa_d    = ffa_q;
    ffb_d    = ffb_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          a_d      = '0;
          b_d      = '0;
          settle_d = '0;
          err_d    = '0;
          ffa_d    = '0;
          ffb_d    = '0;
          pass_d   = 1'b0;
        end
      end
      S_DRIVE: begin
        if (settle_q == c_SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + c_CW'(1);
        end
      end
      S_SAMPLE: begin
        if (w_fail) begin
          err_d = err_q + c_ERR_ONE;
          if (err_q == '0) begin
            ffa_d = a_q;
            ffb_d = b_q;
          end
        end
        if (w_last) begin
          state_d = S_DONE;
          // err_d already includes the final vector's verdict.
          pass_d  = (err_d == '0);
        end else begin
          state_d    = S_DRIVE;
          {a_d, b_d} = w_vec_next;
          settle_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a_out        = a_q;
  assign b_out        = b_q;
  assign busy         = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done         = (state_q == S_DONE);
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmp_sweep_checker
// Description : Bench for cmp_sweep_checker. Two instances (SETTLE=1 and
//               SETTLE=3) face a behavioural comparator with selectable faults
//               and optional garbage outputs outside the sampling cycle.
//               Expected sweep results are queued at start and compared at
//               done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_sweep_checker;

  localparam int W = 4;
  localparam int N = 1 << (2 * W);

  typedef struct {
    logic [2*W:0]   err;
    logic [W-1:0]   fa;
    logic [W-1:0]   fb;
    logic           pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  logic [W-1:0] a1, b1, a3, b3, ffa1, ffb1, ffa3, ffb3;
  logic         gt1, lt1, eq1, gt3, lt3, eq3;
  logic         busy1, done1, pass1, busy3, done3, pass3;
  logic [2*W:0] err1, err3;

  int   checks = 0;
  int   errors = 0;
  int   fault_mode = 0;
  bit   glitch_en = 1'b0;
  int   cyc = 0;
  int   per = 2;
  bit   sel = 1'b0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  cmp_sweep_checker #(.WIDTH(W), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_out(a1), .b_out(b1),
    .gt_in(gt1), .lt_in(lt1), .eq_in(eq1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .first_fail_a(ffa1), .first_fail_b(ffb1)
  );

  cmp_sweep_checker #(.WIDTH(W), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3),
    .gt_in(gt3), .lt_in(lt3), .eq_in(eq3), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(err3), .first_fail_a(ffa3), .first_fail_b(ffb3)
  );

  // Behavioural comparator, returns {gt, lt, eq}.
  // mode 0 golden, 1 eq stuck 0, 2 lt stuck 1, 3 gt/lt swapped.
  function automatic logic [2:0] fault_cmp(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    logic g, l, e;
    g = (a > b);
    l = (a < b);
    e = (a == b);
    case (mode)
      1: e = 1'b0;
      2: l = 1'b1;
      3: begin g = (a < b); l = (a > b); end
      default: ;
    endcase
    return {g, l, e};
  endfunction

  logic w_bad;
  assign w_bad = glitch_en && ((cyc % per) != 0);

  always_comb begin
    {gt1, lt1, eq1} = w_bad ? 3'b101 : fault_cmp(fault_mode, a1, b1);
    {gt3, lt3, eq3} = w_bad ? 3'b101 : fault_cmp(fault_mode, a3, b3);
  end

  logic [W-1:0] w_a, w_b, w_ffa, w_ffb;
  logic         w_busy, w_done, w_pass;
  logic [2*W:0] w_err;
  always_comb begin
    w_a = sel ? a3 : a1;       w_b = sel ? b3 : b1;
    w_ffa = sel ? ffa3 : ffa1; w_ffb = sel ? ffb3 : ffb1;
    w_busy = sel ? busy3 : busy1;
    w_done = sel ? done3 : done1;
    w_pass = sel ? pass3 : pass1;
    w_err = sel ? err3 : err1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sweep-level prediction: walk all pairs in sweep order.
  function automatic exp_t model(input int mode);
    exp_t e;
    logic [2:0] got, want;
    e.err = '0; e.fa = '0; e.fb = '0;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        got  = fault_cmp(mode, W'(a), W'(b));
        want = {a > b, a < b, a == b};
        if (got != want) begin
          if (e.err == '0) begin e.fa = W'(a); e.fb = W'(b); end
          e.err = e.err + 1'b1;
        end
      end
    end
    e.pass = (e.err == '0);
    return e;
  endfunction

  task automatic set_start(input bit s3, input logic v);
    if (s3) start3 = v; else start1 = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, a1, 0);       check({tag, "_b"}, b1, 0);
    check({tag, "_err"}, err1, 0);   check({tag, "_ffa"}, ffa1, 0);
    check({tag, "_ffb"}, ffb1, 0);   check({tag, "_busy"}, busy1, 0);
    check({tag, "_done"}, done1, 0); check({tag, "_pass"}, pass1, 0);
  endtask

  // Cycle n is the clock period ending at edge n, with edge 0 sampling start.
  task automatic run_sweep(input bit s3, input int mode, input bit glitch,
                           input int repulse, input bit hold);
    int   p, total;
    exp_t e;
    p = s3 ? 4 : 2;
    total = N * p;
    sel = s3; fault_mode = mode; per = p; cyc = 0;
    sb_q.push_back(model(mode));
    @(negedge clk);
    set_start(s3, 1'b1);
    glitch_en = glitch;
    @(posedge clk);
    #1;
    if (!hold) set_start(s3, 1'b0);
    for (int n = 1; n <= total + 1; n++) begin
      @(negedge clk);
      cyc = n;
      if (n == repulse) set_start(s3, 1'b1);
      else if (n == repulse + 1) set_start(s3, 1'b0);
      if (n <= total) begin
        check("busy", w_busy, 1);
        check("done_early", w_done, 0);
        check("vec", {w_a, w_b}, (n - 1) / p);
      end else begin
        check("done", w_done, 1);
        check("busy_end", w_busy, 0);
        check("vec_end", {w_a, w_b}, N - 1);
        e = sb_q.pop_front();
        check("err_count", w_err, e.err);
        check("pass", w_pass, e.pass);
        check("first_a", w_ffa, e.fa);
        check("first_b", w_ffb, e.fb);
      end
    end
    glitch_en = 1'b0;
    if (hold) begin
      @(negedge clk);
      check("restart_done", w_done, 0);
      check("restart_busy", w_busy, 1);
      check("restart_vec", {w_a, w_b}, 0);
      check("restart_err", w_err, 0);
      set_start(s3, 1'b0);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Start an eq-stuck sweep on the SETTLE=1 instance and reset at cycle 200.
  task automatic run_abort();
    int exp_err;
    sel = 1'b0; fault_mode = 1; per = 2; cyc = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 1; n < 200; n++) @(negedge clk);
    // Samples at edges 2..198 covered vectors 0..98.
    exp_err = 0;
    for (int i = 0; i <= 98; i++) if ((i / 16) == (i % 16)) exp_err++;
    check("abort_pre_err", err1, exp_err);
    check("abort_pre_busy", busy1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("rst");
    check("rst_busy3", busy3, 0);
    check("rst_done3", done3, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy1, 0);

    run_sweep(1'b0, 0, 1'b0, -1, 1'b0);   // golden
    run_sweep(1'b0, 1, 1'b0, -1, 1'b0);   // eq stuck 0
    run_sweep(1'b0, 2, 1'b0, -1, 1'b0);   // lt stuck 1
    run_sweep(1'b0, 3, 1'b0, -1, 1'b0);   // gt/lt swapped
    run_sweep(1'b0, 0, 1'b1, 100, 1'b0);  // golden, drive glitches, start re-pulse
    run_abort();
    run_sweep(1'b0, 0, 1'b0, -1, 1'b0);   // fresh result after abort
    run_sweep(1'b1, 0, 1'b1, -1, 1'b0);   // SETTLE=3 golden with glitches
    run_sweep(1'b1, 3, 1'b0, -1, 1'b0);   // SETTLE=3 swapped
    run_sweep(1'b0, 2, 1'b0, -1, 1'b1);   // start held high
    do_reset("final");
    check("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
